imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the instruction memory depth in 32-bit words.
REQ-002 Parameter MAX_WAIT, default 4, SHALL set the maximum consecutive cycles a debug request may be denied.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 f_req  input  1  SHALL be the fetch read request.
REQ-006 f_addr  input  32  SHALL be the fetch byte address.
REQ-007 f_gnt  output  1  SHALL indicate that the fetch request is accepted this cycle.
REQ-008 f_rvalid  output  1  SHALL indicate that f_rdata is valid.
REQ-009 f_rdata  output  32  SHALL carry the fetched instruction.
REQ-010 d_req  input  1  SHALL be the debug/loader request.
REQ-011 d_we  input  1  SHALL select a debug write (1) or a debug read (0).
REQ-012 d_addr  input  32  SHALL be the debug byte address.
REQ-013 d_wdata  input  32  SHALL be the debug write data.
REQ-014 d_gnt  output  1  SHALL indicate that the debug request is accepted this cycle.
REQ-015 d_rvalid  output  1  SHALL indicate that d_rdata is valid (reads only).
REQ-016 d_rdata  output  32  SHALL carry the debug read data.
REQ-017 mem_en, mem_we  output  1 each  SHALL drive the memory port enable and write enable.
REQ-018 mem_addr  output  $clog2(DEPTH)  SHALL be the word index.
REQ-019 mem_wdata  output  32; mem_rdata  input  32  SHALL be the memory write and read data; the memory read is synchronous with 1-cycle latency.

Function
REQ-020 Grants SHALL be combinational in the request cycle; at most one of f_gnt and d_gnt SHALL be high in any cycle.
REQ-021 Fetch SHALL have priority over debug unless the starvation counter equals MAX_WAIT, in which case debug SHALL win.
REQ-022 The starvation counter SHALL increment each cycle in which d_req=1 and d_gnt=0, SHALL clear on d_gnt, and SHALL saturate at MAX_WAIT.
REQ-023 On any grant, mem_en SHALL be 1, mem_addr SHALL be address[$clog2(DEPTH)+1:2], and mem_we SHALL equal d_we for debug or 0 for fetch; mem_en SHALL be 0 otherwise.
REQ-024 Address bits [1:0] and the bits above the index SHALL be ignored, so addresses wrap modulo DEPTH words.
REQ-025 A granted read SHALL produce exactly one rvalid pulse to the granted requester in the next cycle, with rdata equal to mem_rdata.
REQ-026 A granted write SHALL produce no rvalid pulse.
REQ-027 A response-owner register SHALL record the requester of each in-flight read, so back-to-back grants to alternating requesters route each response correctly.
REQ-028 f_rdata and d_rdata SHALL hold their last valid value while the corresponding rvalid is 0.
REQ-029 When both requests are present, the starvation counter is at MAX_WAIT, and d_we=1, the write SHALL proceed and fetch SHALL stall exactly one cycle.
REQ-030 When neither request is present, the block SHALL be idle and the counter SHALL hold at 0 (no debug request pending).

Reset
REQ-031 While rst_n=0: f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we = 0; f_rdata, d_rdata, mem_addr, mem_wdata = 0; counter = 0; owner register = fetch.
REQ-032 A read in flight when reset asserts SHALL be discarded, with no rvalid after reset release.

Structure
REQ-033 A shared package imem_pkg SHALL hold IMEM_DEPTH, the IMEM_IDX_W localparam, and the owner_e enum (OWN_FETCH, OWN_DBG).
REQ-034 The block SHALL be one module plus an optional sub-module imem_starve_cnt (saturating counter); the memory array SHALL be external.

Verification
REQ-035 Fetch alone, f_addr=0x8 -> f_gnt the same cycle, mem_addr=2, f_rvalid the next cycle with f_rdata=mem[2].
REQ-036 d_req held with d_we=0 while f_req held continuously, MAX_WAIT=4 -> d_gnt in the 5th cycle and f_gnt=0 in that cycle.
REQ-037 Debug write 0xDEADBEEF to 0x3FC, then fetch of 0x3FC -> mem_we pulse at index 255, then f_rdata=0xDEADBEEF, with no d_rvalid.
REQ-038 Fetch read at 0x400 -> wraps to index 0.
REQ-039 Alternating fetch-read/debug-read grants -> each rvalid asserts only at its own requester with the correct data.
REQ-040 rst_n low the cycle after a grant -> no rvalid, all outputs 0, counter 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory arbiter.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH  = 256;
    localparam int unsigned IMEM_IDX_W  = $clog2(IMEM_DEPTH);
    localparam int unsigned IMEM_DATA_W = 32;

    // Requester that owns the read response currently in flight
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DBG   = 1'b1
    } owner_e;

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating count of consecutive cycles a pending debug request has been denied.
module imem_starve_cnt #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_req,
    input  logic d_gnt,
    output logic at_max_c
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear on grant or when no debug request is pending; otherwise count up to MAX_WAIT
    always_comb begin
        cnt_d = cnt_q;
        if (!d_req || d_gnt) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(MAX_WAIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_c = (cnt_q == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a fetch port and a debug/loader port onto one synchronous
// instruction-memory port, routing each 1-cycle-latency read back to its requester.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH    = IMEM_DEPTH,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     f_req,
    input  logic [31:0]              f_addr,
    output logic                     f_gnt,
    output logic                     f_rvalid,
    output logic [31:0]              f_rdata,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [31:0]              d_addr,
    input  logic [31:0]              d_wdata,
    output logic                     d_gnt,
    output logic                     d_rvalid,
    output logic [31:0]              d_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic        starved_c;
    logic        d_win_c;
    logic        rd_pend_q;
    logic        rd_pend_d;
    owner_e      owner_q;
    owner_e      owner_d;
    logic [31:0] f_rdata_q;
    logic [31:0] f_rdata_d;
    logic [31:0] d_rdata_q;
    logic [31:0] d_rdata_d;

    // Byte offset and bits above the word index are dropped, so addresses wrap
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr[31:IDX_W+2], f_addr[1:0],
                                d_addr[31:IDX_W+2], d_addr[1:0]};

    imem_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_req    (d_req),
        .d_gnt    (d_gnt),
        .at_max_c (starved_c)
    );

    // Grants are issued in the request cycle; rst_n gates them so nothing reaches memory in reset
    always_comb begin
        d_win_c   = d_req && (!f_req || starved_c);
        f_gnt     = rst_n && f_req && !d_win_c;
        d_gnt     = rst_n && d_win_c;
        mem_en    = f_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr = d_addr[IDX_W+1:2];
        end else if (f_gnt) begin
            mem_addr = f_addr[IDX_W+1:2];
        end
        if (mem_we) begin
            mem_wdata = d_wdata;
        end

        f_rvalid = rd_pend_q && (owner_q == OWN_FETCH);
        d_rvalid = rd_pend_q && (owner_q == OWN_DBG);
        f_rdata  = f_rvalid ? mem_rdata : f_rdata_q;
        d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;

        rd_pend_d = f_gnt || (d_gnt && !d_we);
        owner_d   = owner_q;
        if (d_gnt) begin
            owner_d = OWN_DBG;
        end else if (f_gnt) begin
            owner_d = OWN_FETCH;
        end
        f_rdata_d = f_rdata;
        d_rdata_d = d_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            owner_q   <= OWN_FETCH;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            owner_q   <= owner_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_imem_arbiter;

    localparam int unsigned DEPTH    = 256;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic        mem_load = 1'b1;
    logic [31:0] tb_mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // External synchronous memory; read data is scrambled on non-read cycles
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < int'(DEPTH); i++) tb_mem[i] <= 32'hA000_0000 | 32'(i);
        end else if (mem_en && mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            mem_rdata <= $urandom;
        end else if (mem_en) begin
            mem_rdata <= tb_mem[mem_addr];
        end else begin
            mem_rdata <= $urandom;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        f_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic test_reset;
        f_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        d_wdata = 32'h5555_AAAA; d_addr = 32'h40; f_addr = 32'h80;
        @(negedge clk);
        n_cmp++;
        if ({f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we});
        end
        n_cmp++;
        if ({f_rdata, d_rdata, mem_wdata, mem_addr} !== 104'b0) begin
            n_bad++; $display("FAIL reset_data: got %h %h %h %h want all 0", f_rdata, d_rdata, mem_wdata, mem_addr);
        end
        tick;
        mem_load = 1'b0;
        idle;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_fetch_basic;
        f_req = 1'b1; f_addr = 32'h8;
        @(negedge clk);
        n_cmp++;
        if ({f_gnt, d_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 8'd2}) begin
            n_bad++; $display("FAIL fetch_gnt: got %b/%0d want 1010/2", {f_gnt, d_gnt, mem_en, mem_we}, mem_addr);
        end
        tick;
        idle;
        @(negedge clk);
        n_cmp++;
        if ({f_rvalid, d_rvalid, f_rdata} !== {2'b10, 32'hA000_0002}) begin
            n_bad++; $display("FAIL fetch_resp: got %b %h want 10 a0000002", {f_rvalid, d_rvalid}, f_rdata);
        end
        tick;
        @(negedge clk);
        n_cmp++;
        if ({f_rvalid, f_rdata} !== {1'b0, 32'hA000_0002}) begin
            n_bad++; $display("FAIL fetch_hold: got %b %h want 0 a0000002", f_rvalid, f_rdata);
        end
        tick;
    endtask

    task automatic test_starvation;
        f_req = 1'b1; f_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({f_gnt, d_gnt} !== ((c == 5) ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL starve_gnt c%0d: got %b want %b", c, {f_gnt, d_gnt}, (c == 5) ? 2'b01 : 2'b10);
            end
            tick;
        end
        @(negedge clk);
        n_cmp++;
        if ({f_gnt, d_gnt, f_rvalid, d_rvalid, d_rdata} !== {4'b1001, 32'hA000_0004}) begin
            n_bad++; $display("FAIL starve_resp: got %b %h want 1001 a0000004", {f_gnt, d_gnt, f_rvalid, d_rvalid}, d_rdata);
        end
        idle;
        tick;
        tick;
    endtask

    task automatic test_write_then_fetch;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3FC; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, f_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 8'd255, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL wr_port: got %b/%0d/%h want 1011/255/deadbeef", {d_gnt, f_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        tick;
        idle; f_req = 1'b1; f_addr = 32'h3FC;
        @(negedge clk);
        n_cmp++;
        if ({d_rvalid, f_gnt, mem_we, mem_addr} !== {3'b010, 8'd255}) begin
            n_bad++; $display("FAIL wr_norvalid: got %b/%0d want 010/255", {d_rvalid, f_gnt, mem_we}, mem_addr);
        end
        tick;
        idle;
        @(negedge clk);
        n_cmp++;
        if ({f_rvalid, d_rvalid, f_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL wr_readback: got %b %h want 10 deadbeef", {f_rvalid, d_rvalid}, f_rdata);
        end
        tick;
        // Starved debug write against continuous fetch
        f_req = 1'b1; f_addr = 32'h0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234_5678;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({f_gnt, d_gnt, mem_we} !== ((c == 5) ? 3'b011 : 3'b100)) begin
                n_bad++; $display("FAIL stwr_gnt c%0d: got %b want %b", c, {f_gnt, d_gnt, mem_we}, (c == 5) ? 3'b011 : 3'b100);
            end
            tick;
            if (c == 5) d_req = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if ({f_gnt, d_gnt, d_rvalid, f_rvalid} !== 4'b1000) begin
            n_bad++; $display("FAIL stwr_stall1: got %b want 1000", {f_gnt, d_gnt, d_rvalid, f_rvalid});
        end
        tick;
        idle; d_req = 1'b1; d_addr = 32'h44;
        tick;
        idle;
        @(negedge clk);
        n_cmp++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h1234_5678}) begin
            n_bad++; $display("FAIL stwr_readback: got %b %h want 1 12345678", d_rvalid, d_rdata);
        end
        tick;
    endtask

    task automatic test_wrap;
        f_req = 1'b1; f_addr = 32'h400;
        @(negedge clk);
        n_cmp++;
        if ({f_gnt, mem_addr} !== {1'b1, 8'd0}) begin
            n_bad++; $display("FAIL wrap_idx: got %b/%0d want 1/0", f_gnt, mem_addr);
        end
        tick;
        f_addr = 32'hFFFF_F405;
        @(negedge clk);
        n_cmp++;
        if ({mem_addr, f_rvalid, f_rdata} !== {8'd1, 1'b1, 32'hA000_0000}) begin
            n_bad++; $display("FAIL wrap_hi: got %0d %b %h want 1 1 a0000000", mem_addr, f_rvalid, f_rdata);
        end
        tick;
        idle;
        @(negedge clk);
        n_cmp++;
        if (f_rdata !== 32'hA000_0001) begin
            n_bad++; $display("FAIL wrap_data: got %h want a0000001", f_rdata);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        f_req = 1'b1; f_addr = 32'h4;
        tick;
        idle; d_req = 1'b1; d_addr = 32'h8;
        @(negedge clk);
        n_cmp++;
        if ({d_gnt, f_rvalid, d_rvalid, f_rdata} !== {3'b110, 32'hA000_0001}) begin
            n_bad++; $display("FAIL b2b_1: got %b %h want 110 a0000001", {d_gnt, f_rvalid, d_rvalid}, f_rdata);
        end
        tick;
        idle; f_req = 1'b1; f_addr = 32'hC;
        @(negedge clk);
        n_cmp++;
        if ({f_gnt, f_rvalid, d_rvalid, d_rdata, f_rdata} !== {3'b101, 32'hA000_0002, 32'hA000_0001}) begin
            n_bad++; $display("FAIL b2b_2: got %b %h %h want 101 a0000002 a0000001", {f_gnt, f_rvalid, d_rvalid}, d_rdata, f_rdata);
        end
        tick;
        idle;
        @(negedge clk);
        n_cmp++;
        if ({f_rvalid, d_rvalid, f_rdata, d_rdata} !== {2'b10, 32'hA000_0003, 32'hA000_0002}) begin
            n_bad++; $display("FAIL b2b_3: got %b %h %h want 10 a0000003 a0000002", {f_rvalid, d_rvalid}, f_rdata, d_rdata);
        end
        tick;
    endtask

    task automatic test_reset_inflight;
        f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 32'h24; d_addr = 32'h28;
        tick; tick; tick;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we, mem_addr, f_rdata, d_rdata, mem_wdata} !== 110'b0) begin
            n_bad++; $display("FAIL rst_inflight: got %b %0d %h %h want all 0", {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we}, mem_addr, f_rdata, d_rdata);
        end
        tick; tick;
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({f_gnt, d_gnt, f_rvalid, d_rvalid} !== ((c == 5) ? 4'b0110 : ((c == 1) ? 4'b1000 : 4'b1010))) begin
                n_bad++; $display("FAIL rst_after c%0d: got %b", c, {f_gnt, d_gnt, f_rvalid, d_rvalid});
            end
            tick;
        end
        idle;
        tick; tick;
    endtask

    // Reference: memory contents, denial count, and the single outstanding read
    task automatic test_random;
        logic [31:0] ref_mem [DEPTH];
        int          waited;
        bit          pend_v, pend_dbg, f_known, d_known;
        logic [31:0] pend_data, exp_f, exp_d, ga, wd;
        bit          fr, dr, dwe, dwin, efg, edg, efv, edv;
        int          idx;
        idle;
        mem_load = 1'b1;
        tick;
        mem_load = 1'b0;
        tick;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'hA000_0000 | 32'(i);
        waited = 0; pend_v = 0; pend_dbg = 0; pend_data = '0;
        f_known = 0; d_known = 0; exp_f = '0; exp_d = '0;
        for (int n = 0; n < 400; n++) begin
            fr  = ($urandom % 4) != 0;
            dr  = ($urandom % 2) != 0;
            dwe = ($urandom % 3) == 0;
            wd  = $urandom;
            f_req = fr; d_req = dr; d_we = dwe; d_wdata = wd;
            f_addr = $urandom; d_addr = $urandom;
            @(negedge clk);
            efv = pend_v && !pend_dbg;
            edv = pend_v && pend_dbg;
            if (efv) begin exp_f = pend_data; f_known = 1; end
            if (edv) begin exp_d = pend_data; d_known = 1; end
            n_cmp++;
            if ({f_rvalid, d_rvalid} !== {efv, edv}) begin
                n_bad++; $display("FAIL rnd_rvalid n%0d: got %b want %b", n, {f_rvalid, d_rvalid}, {efv, edv});
            end
            if (f_known) begin
                n_cmp++;
                if (f_rdata !== exp_f) begin
                    n_bad++; $display("FAIL rnd_frdata n%0d: got %h want %h", n, f_rdata, exp_f);
                end
            end
            if (d_known) begin
                n_cmp++;
                if (d_rdata !== exp_d) begin
                    n_bad++; $display("FAIL rnd_drdata n%0d: got %h want %h", n, d_rdata, exp_d);
                end
            end
            dwin = dr && (!fr || waited == int'(MAX_WAIT));
            efg  = fr && !dwin;
            edg  = dwin;
            ga   = edg ? d_addr : f_addr;
            idx  = int'((ga >> 2) % DEPTH);
            n_cmp++;
            if ({f_gnt, d_gnt, mem_en, mem_we} !== {efg, edg, efg | edg, edg & dwe}) begin
                n_bad++; $display("FAIL rnd_gnt n%0d: got %b want %b", n, {f_gnt, d_gnt, mem_en, mem_we}, {efg, edg, efg | edg, edg & dwe});
            end
            if (efg || edg) begin
                n_cmp++;
                if (mem_addr !== 8'(idx)) begin
                    n_bad++; $display("FAIL rnd_addr n%0d: got %0d want %0d", n, mem_addr, idx);
                end
            end
            if (edg && dwe) begin
                n_cmp++;
                if (mem_wdata !== wd) begin
                    n_bad++; $display("FAIL rnd_wdata n%0d: got %h want %h", n, mem_wdata, wd);
                end
            end
            pend_v    = efg || (edg && !dwe);
            pend_dbg  = edg;
            pend_data = ref_mem[idx];
            if (edg && dwe) ref_mem[idx] = wd;
            if (edg || !dr) waited = 0;
            else if (waited < int'(MAX_WAIT)) waited++;
            tick;
        end
        idle;
        tick;
    endtask

    initial begin
        test_reset;
        test_fetch_basic;
        test_starvation;
        test_write_then_fetch;
        test_wrap;
        test_back_to_back;
        test_reset_inflight;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
